// File: rtl/demux_pkg.sv
// Shared types and constants for the registered 1:4 demux.
// Also supplies the channel one-hot helper used by the top.
package demux_pkg;

   localparam int NCH  = 4;
   localparam int SELW = 2;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_AUTO   = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   function automatic logic [NCH-1:0] onehot(input logic [SELW-1:0] c);
      return NCH'(1) << c;
   endfunction

endpackage

// File: rtl/demux_rr_ptr.sv
// Mod-4 round-robin channel pointer with increment, clear and hold.
// A clear coinciding with an increment lands on channel 1.
module demux_rr_ptr
   import demux_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            clr_i,
   input  logic            inc_i,
   output logic [SELW-1:0] ptr_o
);

   logic [SELW-1:0] ptr_q;
   logic [SELW-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clr_i) begin
         ptr_d = inc_i ? SELW'(1) : '0;
      end else if (inc_i) begin
         ptr_d = ptr_q + SELW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/demux1_4_reg.sv
// Registered 1:4 demux with direct or round-robin channel steering.
// Tracks written channels per frame and pulses frame_done on completion.
module demux1_4_reg
   import demux_pkg::*;
#(
   parameter int W = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en_n,
   input  logic            mode,
   input  logic [SELW-1:0] sel,
   input  logic [W-1:0]    din,
   input  logic            din_valid,
   input  logic            sync,
   output logic [W-1:0]    q0,
   output logic [W-1:0]    q1,
   output logic [W-1:0]    q2,
   output logic [W-1:0]    q3,
   output logic [NCH-1:0]  q_valid,
   output logic [SELW-1:0] cur_ch,
   output logic            frame_done
);

   state_e          state_q, state_d;
   logic [W-1:0]    q_q [NCH];
   logic [W-1:0]    q_d [NCH];
   logic [NCH-1:0]  qv_q, qv_d;
   logic [NCH-1:0]  mask_q, mask_d;
   logic            fd_q, fd_d;
   logic            mode_q, mode_d;

   logic            run;
   logic            accept;
   logic            sync_go;
   logic            mode_chg;
   logic [SELW-1:0] ptr;
   logic [SELW-1:0] tgt;
   logic [NCH-1:0]  hot;
   logic [NCH-1:0]  mask_nxt;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (!en_n) state_d = RUN;
         RUN:     if (en_n)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Capture decisions follow en_n at the edge, so a falling en_n
   // already accepts the sample presented with it.
   always_comb begin
      run      = (state_d == RUN);
      accept   = run && din_valid;
      sync_go  = run && sync;
      mode_chg = run && (mode != mode_q);
      mode_d   = run ? mode : mode_q;

      if (mode == MODE_AUTO) begin
         tgt = sync_go ? '0 : ptr;
      end else begin
         tgt = sel;
      end
      hot = onehot(tgt);

      mask_nxt = (sync_go || mode_chg) ? '0 : mask_q;
      if (accept) mask_nxt = mask_nxt | hot;
      fd_d   = accept && (mask_nxt == '1);
      mask_d = fd_d ? '0 : mask_nxt;
      qv_d   = accept ? hot : '0;

      for (int k = 0; k < NCH; k++) begin
         q_d[k] = (accept && hot[k]) ? din : q_q[k];
      end
   end

   demux_rr_ptr u_ptr (
      .clk   (clk),
      .rst   (rst),
      .clr_i (sync_go),
      .inc_i (accept && (mode == MODE_AUTO)),
      .ptr_o (ptr)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         qv_q    <= '0;
         mask_q  <= '0;
         fd_q    <= 1'b0;
         mode_q  <= MODE_DIRECT;
         for (int k = 0; k < NCH; k++) q_q[k] <= '0;
      end else begin
         state_q <= state_d;
         qv_q    <= qv_d;
         mask_q  <= mask_d;
         fd_q    <= fd_d;
         mode_q  <= mode_d;
         for (int k = 0; k < NCH; k++) q_q[k] <= q_d[k];
      end
   end

   assign q0         = q_q[0];
   assign q1         = q_q[1];
   assign q2         = q_q[2];
   assign q3         = q_q[3];
   assign q_valid    = qv_q;
   assign frame_done = fd_q;
   assign cur_ch     = (mode == MODE_AUTO) ? ptr : sel;

endmodule

// File: tb/tb_demux1_4_reg.sv
// Directed bench for demux1_4_reg with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_demux1_4_reg;

   logic       clk = 1'b0;
   logic       rst;
   logic       en_n;
   logic       mode;
   logic [1:0] sel;
   logic [0:0] din;
   logic       din_valid;
   logic       sync;
   logic [0:0] q0, q1, q2, q3;
   logic [3:0] q_valid;
   logic [1:0] cur_ch;
   logic       frame_done;

   int n_cmp = 0;
   int n_bad = 0;

   demux1_4_reg #(.W(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .en_n       (en_n),
      .mode       (mode),
      .sel        (sel),
      .din        (din),
      .din_valid  (din_valid),
      .sync       (sync),
      .q0         (q0),
      .q1         (q1),
      .q2         (q2),
      .q3         (q3),
      .q_valid    (q_valid),
      .cur_ch     (cur_ch),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] qs();
      return {4'b0, q3, q2, q1, q0};
   endfunction

   // One auto/direct accept followed by strobe/frame checks.
   task automatic put(input string tag, input logic [1:0] s,
                      input logic d, input logic [3:0] ev,
                      input logic efd);
      sel = s;
      din = d;
      din_valid = 1'b1;
      step();
      chk({tag, "_qv"}, {4'b0, q_valid}, {4'b0, ev});
      chk({tag, "_fd"}, {7'b0, frame_done}, {7'b0, efd});
   endtask

   initial begin
      rst = 1'b1; en_n = 1'b1; mode = 1'b0; sel = 2'd0;
      din = 1'b0; din_valid = 1'b0; sync = 1'b0;
      step(); step();
      chk("rst_q", qs(), 8'h00);
      chk("rst_qv", {4'b0, q_valid}, 8'h00);
      chk("rst_fd", {7'b0, frame_done}, 8'h00);
      chk("rst_ch", {6'b0, cur_ch}, 8'h00);
      rst = 1'b0;

      // direct write to channel 2 on the same cycle en_n falls
      en_n = 1'b0;
      put("t1", 2'd2, 1'b1, 4'b0100, 1'b0);
      chk("t1_q", qs(), 8'b0100);
      din_valid = 1'b0;
      step();
      chk("t1_qv0", {4'b0, q_valid}, 8'h00);

      // auto frame after sync
      mode = 1'b1; sync = 1'b1;
      step();
      chk("t2_ch", {6'b0, cur_ch}, 8'd0);
      sync = 1'b0;
      put("t2a", 2'd0, 1'b1, 4'b0001, 1'b0);
      put("t2b", 2'd0, 1'b0, 4'b0010, 1'b0);
      put("t2c", 2'd0, 1'b1, 4'b0100, 1'b0);
      put("t2d", 2'd0, 1'b1, 4'b1000, 1'b1);
      chk("t2_q", qs(), 8'b1101);
      chk("t2_ch0", {6'b0, cur_ch}, 8'd0);
      din_valid = 1'b0;
      step();
      chk("t2_fd0", {7'b0, frame_done}, 8'h00);

      // sync coincident with an accept restarts the frame
      put("t3a", 2'd3, 1'b0, 4'b0001, 1'b0);
      put("t3b", 2'd3, 1'b0, 4'b0010, 1'b0);
      sync = 1'b1;
      put("t3s", 2'd3, 1'b1, 4'b0001, 1'b0);
      sync = 1'b0;
      chk("t3_q", qs(), 8'b1101);
      chk("t3_ch", {6'b0, cur_ch}, 8'd1);
      put("t3c", 2'd3, 1'b0, 4'b0010, 1'b0);
      put("t3d", 2'd3, 1'b0, 4'b0100, 1'b0);
      put("t3e", 2'd3, 1'b0, 4'b1000, 1'b1);
      chk("t3_q2", qs(), 8'b0001);

      // advance ptr to 1, then freeze with traffic and an ignored sync
      put("t4p", 2'd0, 1'b1, 4'b0001, 1'b0);
      en_n = 1'b1; din = 1'b0; sync = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t4_qv", {4'b0, q_valid}, 8'h00);
         chk("t4_q", qs(), 8'b0001);
         chk("t4_ch", {6'b0, cur_ch}, 8'd1);
      end
      sync = 1'b0;

      // direct mode: rewrites do not advance the frame
      en_n = 1'b0; mode = 1'b0;
      put("t5a", 2'd1, 1'b1, 4'b0010, 1'b0);
      put("t5b", 2'd1, 1'b1, 4'b0010, 1'b0);
      put("t5c", 2'd0, 1'b1, 4'b0001, 1'b0);
      put("t5d", 2'd3, 1'b1, 4'b1000, 1'b0);
      put("t5e", 2'd2, 1'b1, 4'b0100, 1'b1);
      chk("t5_q", qs(), 8'b1111);
      chk("t5_ch", {6'b0, cur_ch}, 8'd2);

      // async reset mid-frame drops the pending strobe
      mode = 1'b1;
      put("t6a", 2'd0, 1'b0, 4'b0010, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("t6_q", qs(), 8'h00);
      chk("t6_qv", {4'b0, q_valid}, 8'h00);
      chk("t6_fd", {7'b0, frame_done}, 8'h00);
      chk("t6_ch", {6'b0, cur_ch}, 8'd0);
      din_valid = 1'b0;
      step();
      rst = 1'b0;
      put("t6b", 2'd3, 1'b1, 4'b0001, 1'b0);
      chk("t6_q1", qs(), 8'b0001);
      chk("t6_ch1", {6'b0, cur_ch}, 8'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/demux1_4_reg.md
Name: demux1_4_reg

Overview:
- Registered 1-to-4 demultiplexer: the receiving end of the team's 4:1 mux path.
- Takes one shared data line and steers each accepted sample into one of four held output registers.
- Channel comes from an explicit select (direct mode) or an internal round-robin pointer (auto mode, paired with a round-robin mux source).
- Active-low enable, per-channel update strobes and a frame-complete pulse.

Parameters:
- W, 1, data width of din and each output channel.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en_n  input  1  active-low enable; 1 = block frozen, no captures.
- mode  input  1  0 = direct (use sel), 1 = auto round-robin.
- sel  input  2  target channel in direct mode; ignored in auto mode.
- din  input  W  shared input data.
- din_valid  input  1  sample present on din this cycle.
- sync  input  1  restart round-robin frame at channel 0.
- q0, q1, q2, q3  output  W each  held channel outputs.
- q_valid  output  4  one-hot strobe; bit k high for one cycle after channel k is written.
- cur_ch  output  2  channel the next accepted sample will go to.
- frame_done  output  1  one-cycle pulse when all four channels have been written since the last frame start.

Behaviour:
- Reset (async, rst=1):
  - q0..q3 = 0, q_valid = 0, frame_done = 0.
  - Pointer ptr = 0, written-mask = 0000, state = IDLE.
  - All hold until rst deasserts.
- Accept condition: en_n=0 and din_valid=1 at a rising clk edge.
- Target channel: sel when mode=0; ptr when mode=1 (after sync handling, see below).
- Latency: on accept, q[target] <= din at that edge; q_valid[target] = 1 for exactly the following cycle; otherwise q_valid = 0.
- Non-target q registers hold. Outputs never go Z; frozen outputs hold their last value.
- State machine:
  - IDLE (en_n=1): no captures; ptr and mask hold; q_valid = 0; frame_done = 0.
  - RUN (en_n=0): captures per the rules above.
  - IDLE->RUN when en_n=0 at an edge; RUN->IDLE when en_n=1 at an edge.
  - A din_valid arriving in the same cycle en_n falls is accepted.
- Round-robin pointer:
  - Increments mod 4 after each accept in auto mode; wrap 3->0.
  - Holds in direct mode.
  - cur_ch = ptr in auto mode, sel in direct mode (combinational from registered ptr/sel).
- sync (while en_n=0):
  - ptr <= 0 and mask <= 0000.
  - If sync and an accept occur in the same cycle: the sample goes to channel 0, ptr becomes 1, mask becomes 0001.
  - sync while en_n=1 is ignored.
- Written-mask:
  - Bit target is set on each accept, in both modes.
  - When the mask would become 1111, frame_done pulses the next cycle (aligned with that q_valid) and the mask clears to 0000.
  - Rewriting an already-set channel does not advance the frame.
- Mode change: any cycle where mode differs from its previous registered value clears the mask. ptr is not reset; only sync resets ptr.
- Reset mid-operation: immediate return to reset values. Pending strobes are dropped.

Decomposition:
- Shared package demux_pkg:
  - NCH = 4, SELW = 2.
  - State type {IDLE, RUN}.
  - Mode constants MODE_DIRECT = 0, MODE_AUTO = 1.
- One sub-module, demux_rr_ptr: 2-bit mod-4 pointer with inc, clear (sync) and hold, async active-high reset.
- Target decode, output registers, mask and frame logic live in the top.

Test Plan:
- Reset release, en_n=0, mode=0, sel=2, din=1, din_valid=1 for one cycle -> q2=1 and q_valid=0100 next cycle; q0/q1/q3 stay 0; frame_done=0.
- mode=1, sync pulse, then four accepts din=1,0,1,1 -> q0..q3=1,0,1,1; q_valid walks 0001, 0010, 0100, 1000; frame_done=1 with the fourth strobe; cur_ch back to 0.
- Auto mode: two accepts, then sync together with an accept din=1 -> that sample lands in q0; cur_ch=1; frame_done only after channels 1,2,3 are written.
- en_n=1 with din_valid=1 for 5 cycles -> no q change; q_valid=0; cur_ch unchanged.
- Direct mode: writes to sel=1,1,0,3 then sel=2 -> frame_done only with the sel=2 strobe.
- rst asserted mid-frame between clock edges -> all q, q_valid and frame_done go 0 immediately; the next sync-less auto accept goes to channel 0.
